// File: rtl/calc_exec.sv
// Accumulator ALU with IDLE/EXEC/DONE handshake.
// Shifts run one bit per clock; all other ops finish on the accept edge.
module calc_exec (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [3:0]  alu_op,
  input  logic [15:0] operand,
  output logic [15:0] acc,
  output logic [2:0]  btn_code,
  output logic        done,
  output logic        err,
  output logic        zero
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  state_t      state, state_n;
  logic [15:0] acc_n;
  logic [2:0]  btn_n;
  logic [3:0]  cnt, cnt_n;
  logic        err_n;
  logic        shr, shr_n;
  logic        legal;
  logic [2:0]  code;

  // Button-encoder code to operation code
  always_comb begin
    legal = 1'b1;
    code  = 3'b000;
    unique case (alu_op)
      4'b0000: code = 3'b000;
      4'b0001: code = 3'b001;
      4'b0010: code = 3'b010;
      4'b0110: code = 3'b011;
      4'b0100: code = 3'b100;
      4'b1001: code = 3'b101;
      4'b1010: code = 3'b110;
      4'b0101: code = 3'b111;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_n = state;
    acc_n   = acc;
    btn_n   = btn_code;
    cnt_n   = cnt;
    err_n   = err;
    shr_n   = shr;
    unique case (state)
      IDLE: begin
        if (op_valid) begin
          state_n = DONE;
          if (!legal) begin
            err_n = 1'b1;
          end else begin
            err_n = 1'b0;
            btn_n = code;
            unique case (code)
              3'b000: acc_n = acc & operand;
              3'b001: acc_n = acc | operand;
              3'b010: acc_n = acc + operand;
              3'b011: acc_n = acc - operand;
              3'b100: acc_n = acc ^ operand;
              3'b111: acc_n = ($signed(acc) < $signed(operand))
                              ? 16'h0001 : 16'h0000;
              default: begin
                if (operand[3:0] != 4'd0) begin
                  cnt_n   = operand[3:0];
                  shr_n   = (code == 3'b110);
                  state_n = EXEC;
                end
              end
            endcase
          end
        end
      end
      EXEC: begin
        acc_n = shr ? (acc >> 1) : (acc << 1);
        cnt_n = cnt - 4'd1;
        if (cnt == 4'd1) state_n = DONE;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= 16'h0000;
      btn_code <= 3'b000;
      cnt      <= 4'd0;
      err      <= 1'b0;
      shr      <= 1'b0;
    end else begin
      state    <= state_n;
      acc      <= acc_n;
      btn_code <= btn_n;
      cnt      <= cnt_n;
      err      <= err_n;
      shr      <= shr_n;
    end
  end

  assign op_ready = (state == IDLE);
  assign done     = (state == DONE);
  assign zero     = (acc == 16'h0000);

endmodule

// File: tb/tb_calc_exec.sv
// Scoreboard bench for calc_exec: driver pushes model results,
// monitor pops and compares on every done pulse.
module tb_calc_exec;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [3:0]  alu_op = 4'h0;
  logic [15:0] operand = 16'h0;
  logic [15:0] acc;
  logic [2:0]  btn_code;
  logic        done;
  logic        err;
  logic        zero;

  calc_exec dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
    .alu_op(alu_op), .operand(operand), .acc(acc),
    .btn_code(btn_code), .done(done), .err(err), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] acc;
    logic [2:0]  btn;
    logic        err;
    logic [3:0]  op;
    int          lat;
    int          t0;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [3:0] enc [8];
  logic [15:0] m_acc = 0;
  logic [2:0]  m_btn = 0;
  logic        m_err = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Reference model: plain arithmetic from the op table
  task automatic model(input logic [3:0] op, input logic [15:0] v,
                       output exp_t e);
    int idx = -1;
    int k;
    for (int i = 0; i < 8; i++) if (enc[i] == op) idx = i;
    e.lat = 1;
    if (idx < 0) begin
      m_err = 1'b1;
    end else begin
      m_err = 1'b0;
      m_btn = 3'(idx);
      k = int'(v[3:0]);
      case (idx)
        0: m_acc = m_acc & v;
        1: m_acc = m_acc | v;
        2: m_acc = 16'((int'(m_acc) + int'(v)) % 65536);
        3: m_acc = 16'((int'(m_acc) - int'(v) + 65536) % 65536);
        4: m_acc = m_acc ^ v;
        5: begin m_acc = 16'((int'(m_acc) * (1 << k)) % 65536); e.lat = k + 1; end
        6: begin m_acc = 16'(int'(m_acc) / (1 << k)); e.lat = k + 1; end
        default: m_acc = (int'($signed(m_acc)) < int'($signed(v))) ? 16'd1 : 16'd0;
      endcase
    end
    e.acc = m_acc;
    e.btn = m_btn;
    e.err = m_err;
    e.op  = op;
  endtask

  // Leaves op_valid high after the accept edge so a following send
  // presents a held request while the DUT is busy.
  task automatic send(input logic [3:0] op, input logic [15:0] v,
                      input bit expect_done);
    exp_t e;
    int n = 0;
    @(negedge clk);
    alu_op = op;
    operand = v;
    op_valid = 1'b1;
    while (!op_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!op_ready) begin
      check("accept_timeout", 0, 1);
      op_valid = 1'b0;
      return;
    end
    model(op, v, e);
    e.t0 = cyc;
    if (expect_done) q.push_back(e);
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    op_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Monitor
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      if (prev_done) check("done_width", 2, 1);
      if (q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = q.pop_front();
        check("acc", int'(acc), int'(e.acc));
        check("btn_code", int'(btn_code), int'(e.btn));
        check("err", int'(err), int'(e.err));
        check("zero", int'(zero), int'(e.acc == 16'h0));
        check("latency", cyc - e.t0, e.lat);
        if (!e.err) check("reencode", int'(enc[btn_code]), int'(e.op));
      end
    end
    prev_done = done;
  end

  initial begin
    int n;
    enc = '{4'b0000, 4'b0001, 4'b0010, 4'b0110,
            4'b0100, 4'b1001, 4'b1010, 4'b0101};
    #2;
    check("rst_acc", int'(acc), 0);
    check("rst_btn", int'(btn_code), 0);
    check("rst_err", int'(err), 0);
    check("rst_done", int'(done), 0);
    check("rst_zero", int'(zero), 1);
    check("rst_ready", int'(op_ready), 1);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", int'(op_ready), 1);

    send(4'b0010, 16'h00FF, 1);
    send(4'b0000, 16'h0000, 1);
    send(4'b0001, 16'h0001, 1);
    send(4'b0110, 16'h0002, 1);
    send(4'b0101, 16'h0000, 1);
    idle(1);
    send(4'b0001, 16'h0002, 1);
    send(4'b1001, 16'h0004, 1);
    send(4'b0000, 16'hFFFF, 1);
    idle(2);
    send(4'b0000, 16'h0000, 1);
    send(4'b0001, 16'h1234, 1);
    send(4'b1111, 16'hABCD, 1);
    send(4'b0001, 16'h0000, 1);
    idle(1);
    for (int i = 0; i < 16; i++) send(4'(i), 16'($urandom), 1);
    idle(3);

    // Reset in the middle of a 15-bit SRL
    send(4'b0001, 16'hF0F0, 1);
    send(4'b1010, 16'h000F, 0);
    op_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_acc", int'(acc), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_ready", int'(op_ready), 1);
    m_acc = 0;
    m_btn = 0;
    m_err = 0;
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("ready_after_midrst", int'(op_ready), 1);
    repeat (18) @(negedge clk);

    for (int i = 0; i < 150; i++) begin
      send(4'($urandom), 16'($urandom), 1);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 3));
    end
    idle(1);

    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) check("drain_timeout", q.size(), 0);
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/calc_exec.md
CALC_EXEC -- requirements
Module: calc_exec

Interface
REQ-001 SHALL have port: clk  input  1  single system clock, all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port: op_valid  input  1  requester has an operation on alu_op/operand.
REQ-004 SHALL have port: op_ready  output  1  block can accept an operation; high only in IDLE.
REQ-005 SHALL have port: alu_op  input  4  operation code produced by the button encoder.
REQ-006 SHALL have port: operand  input  16  right-hand operand (switches); [3:0] is shift amount for shifts.
REQ-007 SHALL have port: acc  output  16  accumulator (left operand and result).
REQ-008 SHALL have port: btn_code  output  3  decoded {btnl,btnc,btnr} of last accepted legal op.
REQ-009 SHALL have port: done  output  1  one-cycle pulse, operation complete.
REQ-010 SHALL have port: err  output  1  last accepted alu_op was illegal.
REQ-011 SHALL have port: zero  output  1  combinational, high when acc == 16'h0000.

Function
REQ-012 SHALL decode alu_op into {btn_code, operation}: 0000->000 AND; 0001->001 OR; 0010->010 ADD; 0110->011 SUB; 0100->100 XOR; 1001->101 SLL; 1010->110 SRL; 0101->111 SLT.
REQ-013 SHALL treat the other eight alu_op values as illegal.
REQ-014 SHALL implement FSM states IDLE, EXEC, DONE; op_ready = (state == IDLE).
REQ-015 SHALL accept an operation on a rising edge where op_valid && op_ready; alu_op and operand are sampled only on that edge.
REQ-016 On accepting AND/OR/ADD/SUB/XOR/SLT, SHALL write acc on the accept edge and go IDLE->DONE.
REQ-017 ADD/SUB SHALL be modulo 2^16 (carry/borrow discarded); SLT SHALL write 16'h0001 if $signed(acc) < $signed(operand), else 16'h0000.
REQ-018 On accepting SLL/SRL with shift amount k = operand[3:0]: k == 0 SHALL leave acc unchanged and go to DONE; k > 0 SHALL load an internal count with k and go to EXEC.
REQ-019 In EXEC, SHALL shift acc by exactly 1 bit per clock (SRL logical, zero fill) and decrement the count; on the edge where count == 1 SHALL go to DONE, so acc is final k edges after the accept edge.
REQ-020 In EXEC and DONE, SHALL ignore op_valid, alu_op and operand; a held op_valid is accepted on the first edge after returning to IDLE.
REQ-021 DONE SHALL last exactly one cycle with done = 1, then go to IDLE; done = 0 in all other states.
REQ-022 On accepting an illegal code, SHALL leave acc and btn_code unchanged, set err = 1, and go to DONE.
REQ-023 On accepting a legal code, SHALL clear err and update btn_code on the accept edge.
REQ-024 Latency, accept edge to done high: 1 cycle for single-step ops, k == 0 shifts and illegal codes; k + 1 cycles for shifts with k > 0.

Reset
REQ-025 While rst = 1, SHALL force state = IDLE, acc = 16'h0000, btn_code = 3'b000, count = 0, err = 0, done = 0, immediately and independently of clk; zero is therefore 1.
REQ-026 rst asserted during EXEC SHALL abandon the shift with no done pulse.
REQ-027 After rst deasserts, op_ready SHALL be 1 in the first cycle.

Verification
REQ-028 Reset, then ADD (0010) with operand 16'h00FF -> done 1 cycle after accept, acc = 16'h00FF, btn_code = 010, err = 0, zero = 0.
REQ-029 acc = 16'h0001, SUB (0110) with operand 16'h0002 -> acc = 16'hFFFF; then SLT (0101) with operand 16'h0000 -> acc = 16'h0001.
REQ-030 acc = 16'h0003, SLL (1001) with operand[3:0] = 4 -> op_ready low for 5 cycles, acc = 16'h0030 when done pulses; new op_valid held in EXEC is accepted only after DONE.
REQ-031 Illegal 1111 with acc = 16'h1234 -> err = 1, acc unchanged, done pulses after 1 cycle; next legal OR (0001) with operand 16'h0000 clears err.
REQ-032 SRL with operand[3:0] = 15, rst pulsed mid-EXEC -> acc = 16'h0000, no done pulse, op_ready = 1 after release.
REQ-033 Exhaustive sweep of all 16 alu_op values -> btn_code/err match the REQ-012 table and btn_code re-encodes to the same alu_op through the button encoder.
